// File: rtl/bcd_timer_chain_pkg.sv
// Shared digit width, stopwatch moduli and per-digit helpers
// for the cascaded BCD timer chain.
package bcd_timer_chain_pkg;

   localparam int DIGIT_W = 4;

   // M:SS.T layout, tenths in the low nibble
   localparam logic [15:0] SW_MODS = {4'd9, 4'd5, 4'd9, 4'd9};

   function automatic logic [DIGIT_W-1:0] clamp_digit(
      input logic [DIGIT_W-1:0] v,
      input logic [DIGIT_W-1:0] max
   );
      return (v > max) ? max : v;
   endfunction

   function automatic logic [DIGIT_W-1:0] step_digit(
      input logic [DIGIT_W-1:0] q,
      input logic [DIGIT_W-1:0] max,
      input logic               up
   );
      logic [DIGIT_W-1:0] r;
      if (up) r = (q == max) ? '0 : q + 1'b1;
      else    r = (q == '0) ? max : q - 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/bcd_timer_chain_digit.sv
// One BCD digit with its own modulus: load-with-clamp,
// wrap in both directions, and terminal flags for the chain.
module bcd_digit
   import bcd_timer_chain_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               en,
   input  logic               up,
   output logic [DIGIT_W-1:0] q,
   output logic               at_max,
   output logic               at_zero
);

   logic [DIGIT_W-1:0] q_q;
   logic [DIGIT_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = clamp_digit(ld_val, MAX);
      end else if (en) begin
         q_d = step_digit(q_q, MAX, up);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q       = q_q;
   assign at_max  = (q_q == MAX);
   assign at_zero = (q_q == '0);

endmodule

// File: rtl/bcd_timer_chain.sv
// NDIG-digit BCD up/down chain with preset, lap capture,
// terminal-count tick and optional stop-at-terminal.
module bcd_timer_chain
   import bcd_timer_chain_pkg::*;
#(
   parameter int                     NDIG = 4,
   parameter logic [DIGIT_W*NDIG-1:0] MODS = SW_MODS
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    en,
   input  logic                    up,
   input  logic                    mode,
   input  logic                    load,
   input  logic [DIGIT_W*NDIG-1:0] load_val,
   input  logic                    lap,
   output logic [DIGIT_W*NDIG-1:0] cnt,
   output logic [DIGIT_W*NDIG-1:0] lap_cnt,
   output logic                    lap_valid,
   output logic                    tc,
   output logic                    done
);

   logic [NDIG-1:0] at_max;
   logic [NDIG-1:0] at_zero;
   logic [NDIG-1:0] dig_term;
   logic [NDIG-1:0] dig_en;
   logic            at_term;
   logic            blocked;
   logic            cnt_en;

   logic [DIGIT_W*NDIG-1:0] lap_q, lap_d;
   logic                    lap_valid_q, lap_valid_d;
   logic                    done_q, done_d;

   assign dig_term = up ? at_max : at_zero;
   assign at_term  = &dig_term;
   assign tc       = en & at_term;

   // A sticky done freezes the count until load or clr
   assign blocked = done_q | (mode & at_term);
   assign cnt_en  = en & ~load & ~blocked;

   always_comb begin
      logic c;
      c      = cnt_en;
      dig_en = '0;
      for (int i = 0; i < NDIG; i++) begin
         dig_en[i] = c;
         c         = c & dig_term[i];
      end
   end

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      bcd_digit #(
         .MAX(MODS[DIGIT_W*g +: DIGIT_W])
      ) u_dig (
         .clk    (clk),
         .clr    (clr),
         .load   (load),
         .ld_val (load_val[DIGIT_W*g +: DIGIT_W]),
         .en     (dig_en[g]),
         .up     (up),
         .q      (cnt[DIGIT_W*g +: DIGIT_W]),
         .at_max (at_max[g]),
         .at_zero(at_zero[g])
      );
   end

   always_comb begin
      done_d      = done_q;
      lap_d       = lap_q;
      lap_valid_d = lap_valid_q;
      if (load) begin
         done_d      = 1'b0;
         lap_valid_d = 1'b0;
      end else begin
         if (en && mode && at_term) done_d = 1'b1;
         if (lap) begin
            lap_d       = cnt;
            lap_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         done_q      <= 1'b0;
         lap_q       <= '0;
         lap_valid_q <= 1'b0;
      end else begin
         done_q      <= done_d;
         lap_q       <= lap_d;
         lap_valid_q <= lap_valid_d;
      end
   end

   assign done      = done_q;
   assign lap_cnt   = lap_q;
   assign lap_valid = lap_valid_q;

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Directed and random checks of bcd_timer_chain against a
// mixed-radix integer model of the count.
module tb_bcd_timer_chain;

   logic        clk = 1'b0;
   logic        clr = 1'b0, en = 1'b0, up = 1'b1, mode = 1'b0;
   logic        load = 1'b0, lap = 1'b0, en2 = 1'b0;
   logic [15:0] load_val = '0;
   logic [23:0] load_val2 = '0;
   logic [15:0] cnt, lap_cnt;
   logic        lap_valid, tc, done;
   logic [23:0] cnt2, lap_cnt2;
   logic        lap_valid2, tc2, done2;

   localparam logic [15:0] M4 = {4'd9, 4'd5, 4'd9, 4'd9};
   localparam logic [23:0] M6 = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

   int checks = 0;
   int failures = 0;

   int mv = 0, mlap = 0, T4 = 1, T6 = 1;
   bit mlv = 0, mdone = 0;

   always #5 clk = ~clk;

   bcd_timer_chain u_dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .mode(mode),
      .load(load), .load_val(load_val), .lap(lap),
      .cnt(cnt), .lap_cnt(lap_cnt), .lap_valid(lap_valid),
      .tc(tc), .done(done)
   );

   bcd_timer_chain #(.NDIG(6), .MODS(M6)) u_dut6 (
      .clk(clk), .clr(clr), .en(en2), .up(up), .mode(mode),
      .load(load), .load_val(load_val2), .lap(lap),
      .cnt(cnt2), .lap_cnt(lap_cnt2), .lap_valid(lap_valid2),
      .tc(tc2), .done(done2)
   );

   function automatic int total(input logic [23:0] m, input int nd);
      int t = 1;
      for (int i = 0; i < nd; i++) t = t * (int'(m[4*i +: 4]) + 1);
      return t;
   endfunction

   function automatic int to_int(input logic [23:0] v,
                                 input logic [23:0] m, input int nd);
      int acc = 0, w = 1, d;
      for (int i = 0; i < nd; i++) begin
         d = int'(v[4*i +: 4]);
         if (d > int'(m[4*i +: 4])) d = int'(m[4*i +: 4]);
         acc = acc + d * w;
         w = w * (int'(m[4*i +: 4]) + 1);
      end
      return acc;
   endfunction

   function automatic logic [23:0] to_bcd(input int x,
                                          input logic [23:0] m, input int nd);
      logic [23:0] r = '0;
      int rad;
      for (int i = 0; i < nd; i++) begin
         rad = int'(m[4*i +: 4]) + 1;
         r[4*i +: 4] = 4'(x % rad);
         x = x / rad;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit e, input bit u, input bit md, input bit ld,
                      input logic [15:0] lv, input bit lp, input bit c);
      bit term;
      en = e; up = u; mode = md; load = ld;
      load_val = lv; lap = lp; clr = c;
      #1;
      term = u ? (mv == T4 - 1) : (mv == 0);
      chk("tc", 32'(tc), 32'(e && term));
      if (c) begin
         mv = 0; mlap = 0; mlv = 0; mdone = 0;
      end else if (ld) begin
         mv = to_int(24'(lv), 24'(M4), 4);
         mdone = 0; mlv = 0;
      end else begin
         if (lp) begin mlap = mv; mlv = 1; end
         if (e && !mdone) begin
            if (md && term) mdone = 1;
            else mv = u ? (mv + 1) % T4 : (mv + T4 - 1) % T4;
         end
      end
      @(posedge clk);
      #1;
      en = 0; load = 0; lap = 0; clr = 0;
      chk("cnt", 32'(cnt), 32'(to_bcd(mv, 24'(M4), 4)));
      chk("lap_cnt", 32'(lap_cnt), 32'(to_bcd(mlap, 24'(M4), 4)));
      chk("lap_valid", 32'(lap_valid), 32'(mlv));
      chk("done", 32'(done), 32'(mdone));
   endtask

   initial begin
      bit u, md;
      T4 = total(24'(M4), 4);
      T6 = total(M6, 6);
      @(posedge clk); #1;

      // reset
      cyc(0, 1, 0, 0, 16'h0000, 0, 1);
      chk("reset_cnt", 32'(cnt), 32'h0);

      // up wrap, 600 ticks -> 1:00.0
      repeat (600) cyc(1, 1, 0, 0, 16'h0, 0, 0);
      chk("up600", 32'(cnt), 32'h1000);
      cyc(0, 1, 0, 1, 16'h9599, 0, 0);
      chk("ld9599", 32'(cnt), 32'h9599);
      cyc(1, 1, 0, 0, 16'h0, 0, 0);
      chk("wrap_up", 32'(cnt), 32'h0000);

      // down stop
      cyc(0, 0, 1, 1, 16'h0003, 0, 0);
      repeat (5) cyc(1, 0, 1, 0, 16'h0, 0, 0);
      chk("down_hold", 32'(cnt), 32'h0000);
      chk("down_done", 32'(done), 32'h1);
      cyc(1, 1, 1, 0, 16'h0, 0, 0);
      chk("dir_flip_blocked", 32'(cnt), 32'h0000);

      // lap
      cyc(0, 1, 0, 1, 16'h0123, 0, 0);
      cyc(1, 1, 0, 0, 16'h0, 1, 0);
      chk("lap_pre", 32'(lap_cnt), 32'h0123);
      chk("lap_cnt_live", 32'(cnt), 32'h0124);
      repeat (10) cyc(1, 1, 0, 0, 16'h0, 0, 0);
      chk("lap_keep", 32'(lap_cnt), 32'h0123);

      // load clamp with simultaneous en and lap
      cyc(1, 1, 0, 1, 16'h97C4, 1, 0);
      chk("clamp", 32'(cnt), 32'h9594);

      // clr overrides all
      cyc(0, 0, 1, 1, 16'h0001, 0, 0);
      repeat (2) cyc(1, 0, 1, 0, 16'h0, 1, 0);
      cyc(1, 1, 1, 1, 16'h3417, 1, 1);
      chk("clr_cnt", 32'(cnt), 32'h0);
      cyc(1, 1, 0, 0, 16'h0, 0, 0);
      chk("after_clr", 32'(cnt), 32'h0001);

      // random
      u = 1; md = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) u = ~u;
         if ($urandom_range(0, 29) == 0) md = ~md;
         cyc($urandom_range(0, 3) != 0, u, md,
             $urandom_range(0, 24) == 0, 16'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
      end

      // six-digit sweep
      cyc(0, 1, 0, 0, 16'h0, 0, 1);
      chk("sweep_reset", 32'(cnt2), 32'h0);
      en2 = 1;
      repeat (3600) @(posedge clk);
      #1;
      en2 = 0;
      chk("sweep3600", 32'(cnt2), 32'(to_bcd(3600 % T6, M6, 6)));
      chk("sweep_done", 32'(done2), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
